// File: rtl/gray_defs.sv
// Shared Gray-code definitions: default width and conversion helpers used by the
// encoder, the decoder side and the scoreboard. Helpers work on zero-extended 32-bit values.
package gray_defs;

    localparam int GRAY_W = 4;

    function automatic logic [31:0] bin_to_gray(input logic [31:0] v);
        return v ^ (v >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic logic [31:0] gray_to_bin(input logic [31:0] v);
        logic [31:0] b;
        b[31] = v[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ v[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/bin2gray.sv
// Combinational binary-to-Gray map, placed ahead of the Gray output register.
module bin2gray #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_bin,
    output logic [W-1:0] o_gray
);

    assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/gray_counter.sv
// Up/down binary counter with registered Gray output, terminal-count flags and a wrap pulse.
// Gray is encoded from the next binary value, so bin and gray are always coherent.
module gray_counter
    import gray_defs::*;
#(
    parameter int W = GRAY_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [W-1:0] load_bin,
    output logic [W-1:0] gray,
    output logic [W-1:0] bin,
    output logic         at_max,
    output logic         at_min,
    output logic         wrap
);

    localparam logic [W-1:0] ONE   = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] ZERO  = '0;
    localparam logic [W-1:0] ALL1  = '1;

    logic [W-1:0] r_bin;
    logic [W-1:0] r_gray;
    logic         r_at_max;
    logic         r_at_min;
    logic         r_wrap;

    logic [W-1:0] w_bin_next;
    logic [W-1:0] w_gray_next;
    logic         w_wrap_next;

    // Load beats stepping; en/up are ignored while loading.
    always_comb begin
        w_bin_next  = r_bin;
        w_wrap_next = 1'b0;
        if (load) begin
            w_bin_next = load_bin;
        end else if (en && up) begin
            w_bin_next  = r_bin + ONE;
            w_wrap_next = (r_bin == ALL1);
        end else if (en) begin
            w_bin_next  = r_bin - ONE;
            w_wrap_next = (r_bin == ZERO);
        end
    end

    bin2gray #(
        .W(W)
    ) u_bin2gray (
        .i_bin (w_bin_next),
        .o_gray(w_gray_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin    <= '0;
            r_gray   <= '0;
            r_at_max <= 1'b0;
            r_at_min <= 1'b1;
            r_wrap   <= 1'b0;
        end else begin
            r_bin    <= w_bin_next;
            r_gray   <= w_gray_next;
            r_at_max <= (w_bin_next == ALL1);
            r_at_min <= (w_bin_next == ZERO);
            r_wrap   <= w_wrap_next;
        end
    end

    assign bin    = r_bin;
    assign gray   = r_gray;
    assign at_max = r_at_max;
    assign at_min = r_at_min;
    assign wrap   = r_wrap;

endmodule

// File: tb/tb_gray_counter.sv
// Directed and random checks of gray_counter against an arithmetic reference model.
module tb_gray_counter;
    import gray_defs::*;

    localparam int W = 4;
    localparam int MOD = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         up = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_bin = '0;
    logic [W-1:0] gray;
    logic [W-1:0] bin;
    logic         at_max;
    logic         at_min;
    logic         wrap;

    int errors = 0;
    int checks = 0;

    int           m_bin = 0;
    logic         m_wrap = 1'b0;
    int           m_kind = 0;      // 0 reset/load, 1 step, 2 hold
    logic [W-1:0] prev_gray = '0;

    always #5 clk = ~clk;

    gray_counter #(.W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .up      (up),
        .load    (load),
        .load_bin(load_bin),
        .gray    (gray),
        .bin     (bin),
        .at_max  (at_max),
        .at_min  (at_min),
        .wrap    (wrap)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [W-1:0] eb;
        logic [W-1:0] eg;
        int hd;
        eb = W'(m_bin);
        eg = W'(m_bin ^ (m_bin / 2));
        hd = $countones(gray ^ prev_gray);
        $display("%s: bin=%b gray=%b max=%b min=%b wrap=%b", tag, bin, gray, at_max, at_min, wrap);
        chk({tag, ".bin"}, 32'(bin), 32'(eb));
        chk({tag, ".gray"}, 32'(gray), 32'(eg));
        chk({tag, ".at_max"}, 32'(at_max), 32'(m_bin == MOD - 1));
        chk({tag, ".at_min"}, 32'(at_min), 32'(m_bin == 0));
        chk({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
        chk({tag, ".decode"}, gray_to_bin(32'(gray)), 32'(bin));
        if (m_kind == 1) chk({tag, ".hamming"}, 32'(hd), 32'd1);
        if (m_kind == 2) chk({tag, ".hold"}, 32'(hd), 32'd0);
        prev_gray = gray;
    endtask

    // Called at a falling edge: drive inputs, advance the model, check at the next falling edge.
    task automatic drive(input logic e, input logic u, input logic l,
                         input logic [W-1:0] lb, input string tag);
        en = e; up = u; load = l; load_bin = lb;
        if (l) begin
            m_bin = int'(lb); m_wrap = 1'b0; m_kind = 0;
        end else if (e && u) begin
            m_wrap = (m_bin == MOD - 1); m_bin = (m_bin + 1) % MOD; m_kind = 1;
        end else if (e) begin
            m_wrap = (m_bin == 0); m_bin = (m_bin + MOD - 1) % MOD; m_kind = 1;
        end else begin
            m_wrap = 1'b0; m_kind = 2;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        en = 0; up = 0; load = 0;
        #2 rst = 1'b1;
        #1;
        m_bin = 0; m_wrap = 1'b0; m_kind = 0;
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Asynchronous reset with no clock edge yet.
        #2 rst = 1'b1;
        #1;
        m_bin = 0; m_wrap = 0; m_kind = 0;
        check_all("reset_async");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) drive(1, 1, 0, '0, $sformatf("up_%0d", i));
        chk("up_final_wrap", 32'(wrap), 32'd1);
        drive(0, 0, 0, '0, "up_after_wrap_hold");

        do_reset("reset_before_down");
        drive(1, 0, 0, '0, "down_wrap");
        chk("down_wrap_gray", 32'(gray), 32'h8);
        drive(1, 0, 0, '0, "down_second");
        chk("down_second_gray", 32'(gray), 32'h9);

        drive(0, 0, 1, 4'b0011, "load_0011");
        drive(1, 1, 1, 4'b1010, "load_priority");
        chk("load_priority_gray", 32'(gray), 32'hF);
        drive(1, 1, 0, '0, "after_load_step");
        chk("after_load_gray", 32'(gray), 32'hE);

        drive(0, 0, 1, 4'b0101, "load_0101");
        for (int i = 0; i < 5; i++) drive(0, 0, 0, '0, $sformatf("hold_%0d", i));
        for (int i = 0; i < 6; i++) drive(1, (i % 2 == 0), 0, '0, $sformatf("toggle_%0d", i));

        // Alternating direction across the boundary keeps wrap high on every step.
        drive(0, 0, 1, 4'b1111, "load_1111");
        for (int i = 0; i < 4; i++) drive(1, (i % 2 == 0), 0, '0, $sformatf("edge_alt_%0d", i));

        drive(0, 0, 1, 4'b1000, "load_1000");
        drive(1, 1, 0, '0, "to_1001");
        do_reset("reset_mid");
        for (int i = 0; i < 3; i++) drive(1, 1, 0, '0, $sformatf("post_reset_up_%0d", i));
        chk("post_reset_gray", 32'(gray), 32'h2);

        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                  ($urandom_range(0, 9) == 0), W'($urandom_range(0, MOD - 1)),
                  $sformatf("rand_%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
